// File: rtl/interval_timer_ctrl_pkg.sv
// Shared definitions for the interval timer controller: FSM state
// encoding and the one-shot/periodic mode values.
package interval_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/interval_timer_ctrl_if.sv
// Configuration handshake, run control and status bundle of the
// interval timer controller.
interface interval_timer_ctrl_if #(
  parameter int Width = 4
) ();

  logic             cfg_valid_i;
  logic             cfg_ready_o;
  logic [Width-1:0] cfg_period_i;
  logic             cfg_periodic_i;
  logic             start_i;
  logic             stop_i;
  logic [Width-1:0] count_o;
  logic             busy_o;
  logic             tick_o;
  logic             done_o;

  // Software-side controller drives configuration and commands
  modport master (
    output cfg_valid_i, cfg_period_i, cfg_periodic_i, start_i, stop_i,
    input  cfg_ready_o, count_o, busy_o, tick_o, done_o
  );

  // Timer side consumes configuration and commands, reports status
  modport slave (
    input  cfg_valid_i, cfg_period_i, cfg_periodic_i, start_i, stop_i,
    output cfg_ready_o, count_o, busy_o, tick_o, done_o
  );

endinterface

// File: rtl/interval_timer_ctrl_sync_ctr.sv
// Basic synchronous up-counter; clear has priority over enable and the
// count wraps modulo 2^Width.
module interval_timer_ctrl_sync_ctr #(
  parameter int Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q;

  // Count register: reset, then clear, then increment
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q <= '0;
    end else if (clr_i) begin
      q <= '0;
    end else if (en_i) begin
      q <= q + {{(Width-1){1'b0}}, 1'b1};
    end
  end

  assign q_o = q;

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer controller: latches period/mode over a valid/ready
// handshake and sequences the up-counter through IDLE/ARMED/RUN/DONE.
// Every output is decoded from registers so no input reaches an output
// combinationally.
module interval_timer_ctrl
  import interval_timer_ctrl_pkg::*;
#(
  parameter int Width = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  interval_timer_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic [Width-1:0] period_q;
  logic             periodic_q;
  logic             ready_q;
  logic [Width-1:0] count;
  logic             accept;
  logic             terminal;
  logic             ctr_en, ctr_clr, load;

  // ready_q mirrors "not in RUN" but is held low through reset
  assign accept   = bus.cfg_valid_i && ready_q;
  assign terminal = (count == period_q);

  interval_timer_ctrl_sync_ctr #(.Width(Width)) u_ctr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (ctr_en),
    .clr_i  (ctr_clr),
    .q_o    (count)
  );

  // Next-state and counter control; stop beats terminal count beats increment
  always_comb begin
    state_d = state_q;
    ctr_en  = 1'b0;
    ctr_clr = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          load    = 1'b1;
          ctr_clr = 1'b1;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED, ST_DONE: begin
        // A configuration accept swallows a simultaneous start
        if (accept) begin
          load    = 1'b1;
          ctr_clr = 1'b1;
          state_d = ST_ARMED;
        end else if (bus.start_i) begin
          ctr_clr = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.stop_i) begin
          ctr_clr = 1'b1;
          state_d = ST_ARMED;
        end else if (terminal) begin
          if (periodic_q == MODE_PERIODIC) begin
            ctr_clr = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          ctr_en = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, configuration and handshake-ready registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      period_q   <= '0;
      periodic_q <= MODE_ONESHOT;
      ready_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != ST_RUN);
      if (load) begin
        period_q   <= bus.cfg_period_i;
        periodic_q <= bus.cfg_periodic_i;
      end
    end
  end

  assign bus.cfg_ready_o = ready_q;
  assign bus.count_o     = count;
  assign bus.busy_o      = (state_q == ST_RUN);
  assign bus.tick_o      = (state_q == ST_RUN) && terminal;
  assign bus.done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Bench for interval_timer_ctrl: a table of directed vectors with
// hand-derived expectations, a few multi-cycle corner sequences and a
// randomized run compared against a behavioural model of the timer.
module tb_interval_timer_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  interval_timer_ctrl_if #(.Width(4)) bus ();

  interval_timer_ctrl #(.Width(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: configured / running / finished flags and an
  // integer count.
  bit m_cfg, m_run, m_fin, m_rdy, m_per;
  int m_cnt, m_p;

  task automatic model_update(input logic rn, va, input logic [3:0] pe,
                              input logic pd, st, sp);
    bit acc;
    if (!rn) begin
      m_cfg = 0; m_run = 0; m_fin = 0; m_rdy = 0; m_per = 0;
      m_cnt = 0; m_p = 0;
      return;
    end
    acc = va && m_rdy;
    if (m_run) begin
      if (sp) begin
        m_run = 0; m_cnt = 0;
      end else if (m_cnt == m_p) begin
        if (m_per) m_cnt = 0;
        else begin m_run = 0; m_fin = 1; end
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else if (acc) begin
      m_cfg = 1; m_p = int'(pe); m_per = pd; m_fin = 0; m_cnt = 0;
    end else if (m_cfg && st) begin
      m_run = 1; m_fin = 0; m_cnt = 0;
    end
    m_rdy = !m_run;
  endtask

  // Apply inputs, clock once, advance the model, sample 1 time unit later
  task automatic step(input logic rn, va, input logic [3:0] pe,
                      input logic pd, st, sp);
    rst_n              = rn;
    bus.cfg_valid_i    = va;
    bus.cfg_period_i   = pe;
    bus.cfg_periodic_i = pd;
    bus.start_i        = st;
    bus.stop_i         = sp;
    @(posedge clk);
    model_update(rn, va, pe, pd, st, sp);
    #1;
  endtask

  task automatic check_exp(input string name, input logic [3:0] cnt,
                           input logic busy, tick, done, rdy);
    n_tests++;
    if (bus.count_o !== cnt || bus.busy_o !== busy || bus.tick_o !== tick ||
        bus.done_o !== done || bus.cfg_ready_o !== rdy) begin
      n_fail++;
      $display("FAIL %s: got cnt=%0d busy=%b tick=%b done=%b rdy=%b, want cnt=%0d busy=%b tick=%b done=%b rdy=%b",
               name, bus.count_o, bus.busy_o, bus.tick_o, bus.done_o, bus.cfg_ready_o,
               cnt, busy, tick, done, rdy);
    end
  endtask

  task automatic check_model(input string name);
    logic [3:0] c;
    c = m_cnt[3:0];
    check_exp(name, c, m_run, m_run && (m_cnt == m_p), m_fin, m_rdy);
  endtask

  typedef struct {
    logic       rst_n, valid;
    logic [3:0] period;
    logic       periodic, start, stop;
    logic [3:0] e_cnt;
    logic       e_busy, e_tick, e_done, e_rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(logic rn, logic va, logic [3:0] pe, logic pd,
                            logic st, logic sp, logic [3:0] c,
                            logic b, logic t, logic d, logic r);
    vec_t x;
    x.rst_n = rn; x.valid = va; x.period = pe; x.periodic = pd;
    x.start = st; x.stop = sp; x.e_cnt = c; x.e_busy = b; x.e_tick = t;
    x.e_done = d; x.e_rdy = r;
    vecs.push_back(x);
  endfunction

  initial begin
    int ticks;
    bit all_busy;

    // rst va P  per st sp | cnt busy tick done rdy
    v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);  // reset
    v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);  // reset held
    v(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);  // IDLE, ready
    v(1, 1, 3, 0, 0, 0,  0, 0, 0, 0, 1);  // cfg P=3 one-shot -> ARMED
    v(1, 0, 0, 0, 1, 0,  0, 1, 0, 0, 0);  // start
    v(1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0);
    v(1, 0, 0, 0, 0, 0,  2, 1, 0, 0, 0);
    v(1, 0, 0, 0, 0, 0,  3, 1, 1, 0, 0);  // tick at P
    v(1, 0, 0, 0, 0, 0,  3, 0, 0, 1, 1);  // DONE, count holds P
    v(1, 0, 0, 0, 1, 0,  0, 1, 0, 0, 0);  // restart from 0
    v(1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0);
    v(1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1);  // stop at 1 -> ARMED
    v(1, 0, 0, 0, 1, 0,  0, 1, 0, 0, 0);  // start again
    v(1, 1, 5, 1, 0, 0,  1, 1, 0, 0, 0);  // cfg in RUN ignored
    v(1, 0, 0, 0, 0, 0,  2, 1, 0, 0, 0);
    v(1, 0, 0, 0, 0, 0,  3, 1, 1, 0, 0);  // still P=3
    v(1, 0, 0, 0, 0, 0,  3, 0, 0, 1, 1);  // DONE
    v(1, 1, 1, 1, 1, 0,  0, 0, 0, 0, 1);  // cfg+start in DONE -> ARMED
    v(1, 0, 0, 0, 1, 0,  0, 1, 0, 0, 0);  // start, P=1 periodic
    v(1, 0, 0, 0, 0, 0,  1, 1, 1, 0, 0);
    v(1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);  // wrap
    v(1, 0, 0, 0, 0, 0,  1, 1, 1, 0, 0);
    v(1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1);  // stop on terminal: ARMED
    v(1, 1, 7, 0, 1, 0,  0, 0, 0, 0, 1);  // cfg+start in ARMED: stays
    v(1, 0, 0, 0, 1, 0,  0, 1, 0, 0, 0);  // start P=7
    v(1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0);
    v(1, 0, 0, 0, 0, 0,  2, 1, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);  // reset at count 2
    v(1, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1);  // start ignored: cfg lost
    v(1, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].valid, vecs[i].period, vecs[i].periodic,
           vecs[i].start, vecs[i].stop);
      check_exp($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_busy,
                vecs[i].e_tick, vecs[i].e_done, vecs[i].e_rdy);
    end

    // Periodic P=2 over 12 RUN cycles
    step(1, 1, 2, 1, 0, 0); check_model("p2_cfg");
    ticks = 0; all_busy = 1;
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 0, (i == 0), 0);
      check_model($sformatf("p2_cyc%0d", i));
      if (bus.tick_o === 1'b1) ticks++;
      if (bus.busy_o !== 1'b1) all_busy = 0;
    end
    n_tests++;
    if (ticks != 4 || !all_busy) begin
      n_fail++;
      $display("FAIL p2_ticks: got ticks=%0d busy_all=%0d, want ticks=4 busy_all=1", ticks, all_busy);
    end
    step(1, 0, 0, 0, 0, 1); check_model("p2_stop");

    // Boundary P=15: tick at 15, then wrap to 0
    step(1, 1, 15, 1, 0, 0); check_model("p15_cfg");
    for (int i = 0; i < 17; i++) begin
      step(1, 0, 0, 0, (i == 0), 0);
      check_model($sformatf("p15_cyc%0d", i));
    end
    check_exp("p15_wrap", 4'd0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1); check_model("p15_stop");

    // Periodic P=0: tick held high
    step(1, 1, 0, 1, 0, 0); check_model("p0_cfg");
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, (i == 0), 0);
      check_exp($sformatf("p0_tick%0d", i), 4'd0, 1, 1, 0, 0);
    end
    step(1, 0, 0, 0, 0, 1); check_model("p0_stop");

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      logic rn, va, pd, st, sp;
      logic [3:0] pe;
      rn = ($urandom_range(0, 99) != 0);
      va = ($urandom_range(0, 3) == 0);
      pe = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                        : 4'($urandom_range(0, 4));
      pd = $urandom_range(0, 1);
      st = ($urandom_range(0, 3) == 0);
      sp = ($urandom_range(0, 15) == 0);
      step(rn, va, pe, pd, st, sp);
      check_model($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
